// File: rtl/shift_count_sequencer.sv
// Control FSM for the shift/count datapath: detects a 4-bit start pattern in SEARCH,
// pulses shift_ena for SHIFT_CYCLES cycles, runs count_ena until done/timeout, then waits for ack.
module shift_count_sequencer #(
  parameter int unsigned SHIFT_CYCLES = 4,
  parameter logic [3:0]  PATTERN      = 4'b1101,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  input  logic done_counting,
  input  logic ack,
  output logic shift_ena,
  output logic count_ena,
  output logic done,
  output logic err,
  output logic busy
);

  localparam int unsigned SW      = $clog2(SHIFT_CYCLES + 1);
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TO_LAST_I);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_SHIFT,
    S_COUNT,
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    hist_q, hist_d;
  logic [1:0]    fill_q, fill_d;
  logic [SW-1:0] shift_cnt_q, shift_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          shift_ena_q, shift_ena_d;
  logic          count_ena_q, count_ena_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    hist_d      = '0;
    fill_d      = '0;
    shift_cnt_d = '0;
    to_cnt_d    = '0;
    unique case (state_q)
      S_SEARCH: begin
        // hist holds only the three previous bits; fill guarantees four SEARCH samples before a match
        hist_d = {hist_q[1:0], data};
        fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        if (fill_q == 2'd3 && {hist_q, data} == PATTERN) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_cnt_q == SHIFT_LAST) state_d = S_COUNT;
        else shift_cnt_d = shift_cnt_q + 1'b1;
      end
      S_COUNT: begin
        to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
        if (done_counting) state_d = S_DONE;
        else if (TIMEOUT != 0 && to_cnt_q == TO_LAST) state_d = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (ack) state_d = S_SEARCH;
      end
      default: state_d = S_SEARCH;
    endcase

    shift_ena_d = (state_d == S_SHIFT);
    count_ena_d = (state_d == S_COUNT);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    busy_d      = (state_d == S_SHIFT) || (state_d == S_COUNT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      shift_cnt_q <= '0;
      to_cnt_q    <= '0;
      shift_ena_q <= 1'b0;
      count_ena_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      shift_cnt_q <= shift_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_ena_q <= shift_ena_d;
      count_ena_q <= count_ena_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign shift_ena = shift_ena_q;
  assign count_ena = count_ena_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_count_sequencer.sv
// Scoreboard bench for shift_count_sequencer: directed stimulus pushes expected output
// vectors {shift_ena,count_ena,done,err,busy}; per-DUT monitors pop and compare each cycle.
module tb_shift_count_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0, data = 1'b0, done_counting = 1'b0, ack = 1'b0;
  logic a_shift, a_count, a_done, a_err, a_busy;
  logic b_shift, b_count, b_done, b_err, b_busy;

  localparam logic [4:0] SRCH = 5'b00000;
  localparam logic [4:0] SH   = 5'b10001;
  localparam logic [4:0] CN   = 5'b01001;
  localparam logic [4:0] DN   = 5'b00100;
  localparam logic [4:0] ER   = 5'b00010;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  shift_count_sequencer #(.SHIFT_CYCLES(4), .PATTERN(4'b1101), .TIMEOUT(4096)) dut_a (
    .clk(clk), .reset(reset), .data(data), .done_counting(done_counting), .ack(ack),
    .shift_ena(a_shift), .count_ena(a_count), .done(a_done), .err(a_err), .busy(a_busy)
  );

  shift_count_sequencer #(.SHIFT_CYCLES(1), .PATTERN(4'b1101), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .data(data), .done_counting(done_counting), .ack(ack),
    .shift_ena(b_shift), .count_ena(b_count), .done(b_done), .err(b_err), .busy(b_busy)
  );

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = qa.pop_front();
      act = {a_shift, a_count, a_done, a_err, a_busy};
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL A:%s got=%b expected=%b (t=%0t)", e.name, act, e.exp, $time);
    end
  end

  always @(negedge clk) begin
    if (qb.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = qb.pop_front();
      act = {b_shift, b_count, b_done, b_err, b_busy};
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL B:%s got=%b expected=%b (t=%0t)", e.name, act, e.exp, $time);
    end
  end

  // Drive inputs for one edge; exp is the output vector seen in the cycle after that edge.
  task automatic step(input logic r, input logic d, input logic dc, input logic a,
                      input logic [4:0] exp, input bit sel_b, input string name);
    exp_t e;
    reset = r; data = d; done_counting = dc; ack = a;
    @(posedge clk);
    e.exp  = exp;
    e.name = name;
    if (sel_b) qb.push_back(e);
    else qa.push_back(e);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int unsigned n,
                           input logic [4:0] last_exp, input bit sel_b, input string name);
    for (int i = int'(n) - 1; i >= 0; i--)
      step(1'b1, bits[i], 1'b0, 1'b0, (i == 0) ? last_exp : SRCH, sel_b, name);
  endtask

  initial begin
    // ---------------- DUT A: SHIFT_CYCLES=4, TIMEOUT=4096 ----------------
    step(1'b0, 1'b0, 1'b0, 1'b0, SRCH, 1'b0, "reset0");
    step(1'b0, 1'b1, 1'b1, 1'b1, SRCH, 1'b0, "reset1");

    send_bits(8'b0000_1101, 4, SH, 1'b0, "match_1101");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, SH, 1'b0, "shift_hold");
    step(1'b1, 1'b1, 1'b0, 1'b1, CN, 1'b0, "enter_count");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1, CN, 1'b0, "count_hold_ack_ignored");
    step(1'b1, 1'b0, 1'b1, 1'b0, DN, 1'b0, "done_rise");
    begin
      logic [4:0] done_bits;
      done_bits = 5'b11011;
      for (int i = 4; i >= 0; i--) step(1'b1, done_bits[i], 1'b0, 1'b0, DN, 1'b0, "done_hold");
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, SRCH, 1'b0, "ack_return");
    send_bits(8'b0010_1101, 6, SH, 1'b0, "no_leak_match");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, SH, 1'b0, "shift_hold2");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b0, "enter_count2");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b0, "count2");
    step(1'b0, 1'b0, 1'b1, 1'b0, SRCH, 1'b0, "reset_mid_count");

    send_bits(8'b0001_1101, 5, SH, 1'b0, "overlap_11101");
    step(1'b1, 1'b0, 1'b0, 1'b0, SH, 1'b0, "shift_cycle2");
    step(1'b0, 1'b0, 1'b0, 1'b0, SRCH, 1'b0, "reset_mid_shift");
    send_bits(8'b0000_1101, 4, SH, 1'b0, "restart_1101");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, SH, 1'b0, "restart_shift_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b0, "restart_count");
    step(1'b1, 1'b0, 1'b1, 1'b0, DN, 1'b0, "restart_done");
    step(1'b1, 1'b0, 1'b0, 1'b1, SRCH, 1'b0, "restart_ack");

    send_bits(8'b1100_1101, 8, SH, 1'b0, "overlap_11001101");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, SH, 1'b0, "ov2_shift_hold");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b0, "ov2_count");

    // ---------------- DUT B: SHIFT_CYCLES=1, TIMEOUT=8 ----------------
    step(1'b0, 1'b0, 1'b0, 1'b0, SRCH, 1'b1, "b_reset");
    send_bits(8'b0000_1101, 4, SH, 1'b1, "b_match");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b1, "b_single_shift");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b1, "b_count_to");
    step(1'b1, 1'b0, 1'b0, 1'b0, ER, 1'b1, "b_timeout_err");
    step(1'b1, 1'b0, 1'b0, 1'b0, ER, 1'b1, "b_err_hold");
    step(1'b1, 1'b0, 1'b0, 1'b1, SRCH, 1'b1, "b_err_ack");
    send_bits(8'b0000_1101, 4, SH, 1'b1, "b_match2");
    step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b1, "b_enter_count2");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, CN, 1'b1, "b_count2");
    step(1'b1, 1'b0, 1'b1, 1'b0, DN, 1'b1, "b_done_beats_timeout");
    step(1'b1, 1'b0, 1'b0, 1'b1, SRCH, 1'b1, "b_done_ack");

    for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: pending=%0d required=0", qa.size() + qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_count_sequencer.md
Name: shift_count_sequencer

Overview:
Control FSM for the shift/count datapath. It watches a serial bit stream for a 4-bit start pattern. On a match it asserts shift_ena for exactly SHIFT_CYCLES cycles so the datapath loads its delay value, then asserts count_ena until the datapath reports done_counting. It then raises done (or err on timeout) and holds it until ack. The block sits between the serial command input and the shift/count register block.

Parameters:
SHIFT_CYCLES, 4, number of consecutive cycles shift_ena is held high after a pattern match (>=1)
PATTERN, 4'b1101, start sequence; oldest bit is MSB, newest bit is LSB
TIMEOUT, 4096, maximum cycles allowed in COUNT before error; 0 disables the timeout

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
data  input  1  serial bit stream, sampled every cycle while in SEARCH
done_counting  input  1  datapath count finished; sampled only in COUNT
ack  input  1  user acknowledge; sampled only in DONE/ERR
shift_ena  output  1  datapath shift enable
count_ena  output  1  datapath count enable
done  output  1  sequence completed normally
err  output  1  count phase timed out
busy  output  1  high in SHIFT or COUNT

Behaviour:
- States: SEARCH, SHIFT, COUNT, DONE, ERR. Every output is Moore (a function of state only). shift_ena and count_ena are never high together.
- Reset (reset==0 at an edge): state=SEARCH, hist=0, shift counter=0, timeout counter=0. All outputs are 0 in the following cycle. Reset wins over every other event, including mid-SHIFT and mid-COUNT.
- SEARCH: hist <= {hist[2:0], data} every edge. A match is when {hist[2:0], data} == PATTERN at an edge; the next state is SHIFT. Overlap is inherent, but hist is cleared to 0 on every entry to SEARCH. Four bits sampled in SEARCH are therefore needed before a match, and bits seen in other states never contribute.
- SHIFT: shift_ena=1, busy=1. The counter loads 0 on entry and increments each edge. After exactly SHIFT_CYCLES cycles in SHIFT the next state is COUNT. Counter width is clog2(SHIFT_CYCLES+1). data is ignored.
- COUNT: count_ena=1, busy=1. The timeout counter loads 0 on entry and increments each cycle. If done_counting==1 at an edge, the next state is DONE; count_ena is still 1 in that cycle. Otherwise, if TIMEOUT!=0 and the counter reaches TIMEOUT-1 at the edge, the next state is ERR (exactly TIMEOUT cycles in COUNT). done_counting has priority over timeout on the same edge. The counter saturates and never wraps.
- DONE: done=1, everything else 0. If ack==1 at an edge, the next state is SEARCH; otherwise stay. ack is ignored in all other states.
- ERR: err=1, everything else 0. Same ack handling as DONE.
- Latency: the last matching bit at edge N gives shift_ena=1 for cycles N+1..N+SHIFT_CYCLES and count_ena=1 from cycle N+SHIFT_CYCLES+1.
- X/undefined inputs are not tolerated. No illegal state is reachable; the default branch returns to SEARCH.

Test Plan:
- Reset, then data=1,1,0,1 on four edges -> shift_ena=1 for exactly 4 cycles starting the cycle after the 4th bit, then count_ena=1; done=err=0, busy=1 throughout.
- Overlap: data=1,1,1,0,1 -> match on the 5th bit, first shift_ena one cycle later; data=1,1,0,0,1,1,0,1 -> match on the 8th bit only.
- COUNT held 10 cycles, then done_counting=1 for one edge -> count_ena drops, done=1 next cycle and holds with ack=0 for 5 cycles; ack=1 -> SEARCH, done=0. A fresh 1101 after return starts a new sequence, and bits sent during DONE are ignored.
- TIMEOUT=8 with done_counting held 0 -> count_ena high exactly 8 cycles, then err=1. done_counting=1 and timeout on the same edge -> done=1, err=0.
- reset=0 asserted during the 2nd SHIFT cycle and separately mid-COUNT -> all outputs 0 next cycle; a following 1101 restarts the full 4-cycle shift.
- SHIFT_CYCLES=1 override -> a single shift_ena pulse, then COUNT.
